// File: rtl/timer256.sv
// 256 Hz free-running timer with 32/8/2/1 Hz interrupt pulses, bus registers at $2040-$2041.
// Define TIMER256_FASTSIM_EN to force an effective prescale of 2 for fast simulation.
module timer256 #(
  parameter int PRESCALE = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        osc_tick,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        irq_32hz,
  output logic        irq_8hz,
  output logic        irq_2hz,
  output logic        irq_1hz
);

`ifdef TIMER256_FASTSIM_EN
  localparam int EFF_PRESCALE = 2;
`else
  localparam int EFF_PRESCALE = PRESCALE;
`endif
  localparam int PW = (EFF_PRESCALE > 1) ? $clog2(EFF_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(EFF_PRESCALE - 1);

  localparam logic [23:0] ADDR_CTRL  = 24'h002040;
  localparam logic [23:0] ADDR_COUNT = 24'h002041;

  logic          enable_q, enable_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    count_inc;
  logic [3:0]    irq_q, irq_d;
  logic          ctrl_wr, ctrl_clr;

  // Reads have no side effects; only the low two control bits are meaningful.
  logic unused_inputs;
  assign unused_inputs = ^{bus_read, bus_data_in[7:2]};

  assign ctrl_wr  = bus_write && (bus_address_in == ADDR_CTRL);
  assign ctrl_clr = ctrl_wr && bus_data_in[1];

  always_comb begin
    enable_d  = enable_q;
    presc_d   = presc_q;
    count_d   = count_q;
    irq_d     = '0;
    count_inc = count_q + 8'd1;
    if (ctrl_wr)
      enable_d = bus_data_in[0];
    // Clear beats a coincident increment; a tick uses the enable value from before the write.
    if (ctrl_clr) begin
      presc_d = '0;
      count_d = '0;
    end else if (osc_tick && enable_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        count_d = count_inc;
        irq_d   = {count_inc[2:0] == 3'd0, count_inc[4:0] == 5'd0,
                   count_inc[6:0] == 7'd0, count_inc == 8'd0};
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
      presc_q  <= '0;
      count_q  <= '0;
      irq_q    <= '0;
    end else begin
      enable_q <= enable_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  assign {irq_32hz, irq_8hz, irq_2hz, irq_1hz} = irq_q;

  always_comb begin
    bus_data_out = '0;
    if (bus_address_in == ADDR_CTRL)
      bus_data_out = {7'd0, enable_q};
    else if (bus_address_in == ADDR_COUNT)
      bus_data_out = count_q;
  end

endmodule

// File: tb/tb_timer256.sv
// Randomized scoreboard bench for timer256: a tick-count model predicts reads and IRQ pulses.
module tb_timer256;

`ifdef TIMER256_FASTSIM_EN
  localparam int P = 2;
`else
  localparam int P = 128;
`endif
  localparam int WRAP = 256 * P;

  logic        clk = 1'b0;
  logic        reset;
  logic        osc_tick, bus_write, bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in, bus_data_out;
  logic        irq_32hz, irq_8hz, irq_2hz, irq_1hz;

  timer256 #(.PRESCALE(128)) dut (
    .clk(clk), .reset(reset), .osc_tick(osc_tick), .bus_write(bus_write),
    .bus_read(bus_read), .bus_address_in(bus_address_in), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .irq_32hz(irq_32hz), .irq_8hz(irq_8hz),
    .irq_2hz(irq_2hz), .irq_1hz(irq_1hz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic [3:0] mask;
  } irq_exp_t;

  irq_exp_t   irq_q[$];
  logic [7:0] rd_q[$];
  int checks = 0;
  int errors = 0;

  // Model: enable flag and ticks counted since the last clear, modulo one full counter wrap.
  bit          en_m = 1'b0;
  int unsigned tk   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [23:0] a);
    if (a == 24'h002040) return {7'd0, en_m};
    if (a == 24'h002041) return 8'(tk / P);
    return 8'h00;
  endfunction

  // Monitor: compares reads and IRQ pulses against the queued expectations.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_read) begin
        if (rd_q.size() == 0) chk("read_unexpected", 1, 0);
        else chk($sformatf("read_%0h", bus_address_in), bus_data_out, rd_q.pop_front());
      end
      if ({irq_32hz, irq_8hz, irq_2hz, irq_1hz} != 4'b0) begin
        if (irq_q.size() == 0) begin
          chk("irq_unexpected", {irq_32hz, irq_8hz, irq_2hz, irq_1hz}, 0);
        end else begin
          irq_exp_t e;
          e = irq_q.pop_front();
          chk("irq_mask", {irq_32hz, irq_8hz, irq_2hz, irq_1hz}, e.mask);
          chk("irq_cycle", cyc, e.stamp);
        end
      end
    end
  end

  // One bus/osc cycle; called at posedge+1 and returns at the next posedge+1.
  task automatic step(input bit tick, input bit wr, input logic [23:0] a,
                      input logic [7:0] d, input bit rd);
    bit          en_old, clr;
    int unsigned n;
    irq_exp_t    e;
    osc_tick = tick; bus_write = wr; bus_address_in = a; bus_data_in = d; bus_read = rd;
    if (rd) rd_q.push_back(model_read(a));
    @(posedge clk); #1;
    en_old = en_m;
    clr    = 1'b0;
    if (wr && a == 24'h002040) begin
      en_m = d[0];
      clr  = d[1];
    end
    if (clr) begin
      tk = 0;
    end else if (tick && en_old) begin
      tk = (tk + 1) % WRAP;
      if (tk % P == 0) begin
        n      = tk / P;
        e.stamp = cyc;
        e.mask  = {(n % 8) == 0, (n % 32) == 0, (n % 128) == 0, n == 0};
        if (e.mask != 4'b0) irq_q.push_back(e);
      end
    end
  endtask

  task automatic rnd_step();
    int          r;
    logic [23:0] a;
    r = $urandom_range(0, 15);
    case ($urandom_range(0, 3))
      0:       a = 24'h002040;
      1:       a = 24'h002041;
      2:       a = 24'h002042;
      default: a = {4'hF, 20'($urandom)};
    endcase
    if (r == 0)      step($urandom_range(0, 15) != 0, 1'b1, 24'h002041, 8'($urandom), 1'b0);
    else if (r == 1) step($urandom_range(0, 15) != 0, 1'b1, {4'hF, 20'($urandom)}, 8'($urandom), 1'b0);
    else             step($urandom_range(0, 15) != 0, 1'b0, a, 8'h00, r < 5);
  endtask

  task automatic run_to(input int unsigned target);
    int g = 0;
    while (tk != target) begin
      rnd_step();
      g++;
      if (g > 60000) begin
        $display("FAIL run_to_timeout: tk %0d expected %0d", tk, target);
        $fatal(1, "run_to bound expired");
      end
    end
  endtask

  task automatic rd(input logic [23:0] a);
    step(1'b0, 1'b0, a, 8'h00, 1'b1);
  endtask

  initial begin
    reset = 1'b1; osc_tick = 0; bus_write = 0; bus_read = 0;
    bus_address_in = 24'h002041; bus_data_in = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_irqs", {irq_32hz, irq_8hz, irq_2hz, irq_1hz}, 0);
    chk("reset_count", bus_data_out, 0);
    bus_address_in = 24'h002040; #1;
    chk("reset_enable", bus_data_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    rd(24'h002040);
    rd(24'h002041);
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 24'h002041, 8'h00, $urandom_range(0, 3) == 0);
    rd(24'h002041);

    step(1'b0, 1'b1, 24'h002040, 8'h01, 1'b0);
    run_to(P);
    rd(24'h002041);
    run_to(8 * P);
    rd(24'h002041);

    // Full wrap, then async reset while the all-four pulse is high.
    run_to(WRAP - 1);
    step(1'b1, 1'b0, 24'h002041, 8'h00, 1'b0);
    @(negedge clk); #2;
    reset = 1'b1; #1;
    chk("async_reset_irqs", {irq_32hz, irq_8hz, irq_2hz, irq_1hz}, 0);
    en_m = 1'b0; tk = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    rd(24'h002040);
    rd(24'h002041);

    step(1'b0, 1'b1, 24'h002040, 8'h01, 1'b0);
    run_to(16 * P - 1);
    step(1'b1, 1'b1, 24'h002040, 8'h00, 1'b0);
    for (int i = 0; i < 50; i++) rnd_step();
    rd(24'h002040);
    rd(24'h002041);
    step(1'b0, 1'b1, 24'h002040, 8'h01, 1'b0);
    run_to(8'h37 * P - 1);
    step(1'b1, 1'b1, 24'h002040, 8'h03, 1'b0);
    rd(24'h002040);
    rd(24'h002041);
    run_to(P - 1);
    rd(24'h002041);
    step(1'b1, 1'b0, 24'h002041, 8'h00, 1'b0);
    rd(24'h002041);

    step(1'b0, 1'b1, 24'h002041, 8'hAA, 1'b0);
    rd(24'h002041);
    step(1'b0, 1'b1, 24'h002040, 8'hFF, 1'b0);
    rd(24'h002040);
    rd(24'h002041);
    rd(24'h002042);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 24'h000000, 8'h00, 1'b0);
    chk("irq_queue_drained", irq_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
